ad9361_adc_pack: RTL and testbench
==================================

# ad9361_adc_pack

Receive-side packer that sits directly downstream of the AD9361 device interface in the `clk` domain. It consumes the interface's 48-bit, four-channel sample stream (`adc_valid`/`adc_data`/`adc_status`) and keeps only the enabled channels. Each kept 12-bit sample is widened to 16 bits and packed into 64-bit words. Packed words go through a small FIFO to a valid/ready stream for DMA, with bounded or continuous captures, a last-word marker, and sticky overflow and status-error flags.

## Interface
- `FIFO_AW`, 4: FIFO address width; depth is 2^FIFO_AW 65-bit entries (64 data + last).
- `clk`  in  1  sample clock, same clock as the device interface's receive outputs.
- `rst`  in  1  synchronous, active-high reset.
- `adc_valid`  in  1  one sample set present this cycle.
- `adc_data`  in  48  [11:0]=I0, [23:12]=Q0, [35:24]=I1, [47:36]=Q1.
- `adc_status`  in  1  1 = frame alignment good.
- `cfg_enable`  in  4  channel mask: bit0=I0, bit1=Q0, bit2=I1, bit3=Q1. Sampled on `cap_start`.
- `cfg_signext`  in  1  1 = sign-extend to 16 bits; 0 = left-align (sample<<4). Sampled on `cap_start`.
- `cap_count`  in  16  words to capture; 0 = continuous. Sampled on `cap_start`.
- `cap_start`  in  1  one-cycle pulse; honoured only in IDLE.
- `cap_stop`  in  1  one-cycle pulse; ends a continuous capture at the next word boundary.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  64  packed word.
- `m_last`  out  1  final word of the capture.
- `busy`  out  1  capture in progress (RUN or DRAIN).
- `ovf`  out  1  sticky: a word was dropped because the FIFO was full.
- `status_err`  out  1  sticky: `adc_valid` arrived with `adc_status`=0 during RUN.
- `cfg_err`  out  1  sticky: `cap_start` was issued with an illegal mask.

## Operation
- FSM states are IDLE, RUN and DRAIN. Reset enters IDLE.
- IDLE → RUN on `cap_start` when popcount(`cfg_enable`) ∈ {1,2,4}.
  - On that transition: latch the configuration, clear `ovf`/`status_err`/`cfg_err`, zero the lane counter and word counter, and empty the accumulator.
  - If the popcount is 0 or 3: stay in IDLE and set `cfg_err`.
  - `cap_start` in RUN or DRAIN is ignored.
- RUN, for each `adc_valid`:
  - The enabled channels, in order I0,Q0,I1,Q1, are converted to 16 bits and written into the next free 16-bit lanes.
  - Lane 0 is [15:0]; the first enabled channel of the first sample lands there.
  - With popcount 1, 2 or 4, a word completes after 4, 2 or 1 valid samples respectively. Samples never straddle words.
- A completed word is pushed with `last` set if either of these holds:
  - `cap_count`≠0 and this is word number `cap_count`; or
  - a stop has been latched (`cap_stop` seen in RUN, held until used).
  - A pushed word with `last` set moves the FSM to DRAIN.
- FIFO full when a word completes: the word is dropped and `ovf` is set. The word counter still advances, so a dropped last word still moves the FSM to DRAIN; no `m_last` appears in that case.
- DRAIN → IDLE when the FIFO is empty and no read is pending.
- `adc_valid` outside RUN is ignored. A partial accumulator at stop is completed by further samples; it is never zero-padded.
- `rst` mid-capture flushes the FIFO, the accumulator and all flags immediately.

## Timing
- Reset values: all outputs are 0.
- Accumulator update registers on the cycle of `adc_valid`. The completed word is pushed one cycle later.
- With the FIFO empty, `m_valid` rises 2 cycles after the `adc_valid` that completes the word.
- The FIFO is first-word-fall-through. `m_data`/`m_last` are stable while `m_valid`=1 and `m_ready`=0. One pop per cycle when `m_valid`&&`m_ready`.
- A push and a pop in the same cycle with the FIFO full is not an overflow: full is evaluated after the pop.
- Sustained input up to one `adc_valid` per cycle with popcount 4.
- `cap_stop` in the same cycle as a word completing applies to that word.
- `busy` rises the cycle after an accepted `cap_start` and falls the cycle after the FIFO empties in DRAIN.

## Structure
- Package `ad9361_pack_pkg` holds:
  - FSM state enum `pack_state_t` {IDLE, RUN, DRAIN};
  - constants `SAMPLE_W`=12, `LANE_W`=16, `LANES`=4, `WORD_W`=64;
  - function `lanes_per_sample(mask)`.
- Sub-module `ad_sfifo` (generic synchronous FWFT FIFO, parameters WIDTH/AW, outputs `full`/`empty`). Packing and FSM logic stay in the top module.

## Test plan
- Mask 4'b1111, `cfg_signext`=1, `cap_count`=2; samples I0=0x800, Q0=0x7FF, I1=0x001, Q1=0xFFF, then all 0x123 → words 0xFFFF_0001_07FF_F800 and 0x0123_0123_0123_0123, second with `m_last`=1; `busy` returns to 0.
- Mask 4'b0001, `cfg_signext`=0, `cap_count`=1; I0 = 0x001,0x002,0x003,0x004 → one word 0x0040_0030_0020_0010 with `m_last`=1, `m_valid` 2 cycles after the 4th `adc_valid`.
- Mask 4'b0011, continuous; 3 samples then `cap_stop`, then 1 more sample → 2 words, only the second with `m_last`; no further words after more `adc_valid`.
- `FIFO_AW`=4, mask 4'b1111, continuous, `m_ready`=0 for 20 samples → 16 words held, `ovf`=1. Then `m_ready`=1 → exactly 16 words drained in order.
- `cap_start` with mask 4'b0111 → `cfg_err`=1, `busy`=0, no output. Then a legal start clears `cfg_err`.
- `adc_status`=0 on one sample during RUN → `status_err`=1 and the data is still packed. `rst` asserted mid-capture → `m_valid`=0, `busy`=0 and all flags 0 on the next cycle.

Source files
------------

// File: rtl/ad9361_pack_pkg.sv
// Shared types and constants for the AD9361 receive packer.
//   pack_state_t     : capture FSM states
//   SAMPLE_W/LANE_W  : raw sample width and widened lane width
//   LANES/WORD_W     : lanes per packed word and packed word width
//   lanes_per_sample : number of enabled channels (lanes consumed per sample set)
package ad9361_pack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pack_state_t;

  localparam int SAMPLE_W = 12;
  localparam int LANE_W   = 16;
  localparam int LANES    = 4;
  localparam int WORD_W   = 64;

  function automatic logic [2:0] lanes_per_sample(input logic [3:0] mask);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, mask[i]};
    return n;
  endfunction

endpackage

// File: rtl/ad_sfifo.sv
// Generic synchronous first-word-fall-through FIFO.
//   clk/rst : clock, synchronous active-high reset (empties the FIFO)
//   wr_en   : write request; accepted when not full, or when a read frees a slot
//             in the same cycle
//   rd_en   : read request; ignored while empty
//   rd_data : head entry, valid whenever !empty (forced to 0 while empty)
//   full    : 2^AW entries held
//   empty   : no entries held
module ad_sfifo #(
  parameter int WIDTH = 65,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem [2**AW];
  logic             do_wr, do_rd;

  assign full  = cnt_q[AW];
  assign empty = (cnt_q == '0);
  assign do_rd = rd_en && !empty;
  // Full is judged after the same-cycle pop.
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ad9361_adc_pack.sv
// AD9361 receive packer: keeps enabled channels of the 4-channel 12-bit sample
// stream, widens each to 16 bits and packs them into 64-bit words delivered
// through a FWFT FIFO on a valid/ready stream.
//   clk/rst                : sample clock, synchronous active-high reset
//   adc_valid/data/status  : sample set from the device interface
//   cfg_enable/signext     : channel mask and widening mode (latched on start)
//   cap_count              : words per capture, 0 = continuous (latched on start)
//   cap_start/cap_stop     : capture control pulses
//   m_valid/ready/data/last: packed word stream
//   busy                   : capture in RUN or DRAIN
//   ovf/status_err/cfg_err : sticky error flags, cleared by a legal start
module ad9361_adc_pack
  import ad9361_pack_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_valid,
  input  logic [47:0] adc_data,
  input  logic        adc_status,
  input  logic [3:0]  cfg_enable,
  input  logic        cfg_signext,
  input  logic [15:0] cap_count,
  input  logic        cap_start,
  input  logic        cap_stop,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        ovf,
  output logic        status_err,
  output logic        cfg_err
);

  pack_state_t                   state_q, state_d;
  logic [3:0]                    mask_q, mask_d;
  logic                          signext_q, signext_d;
  logic [15:0]                   count_q, count_d;
  logic [15:0]                   wcnt_q, wcnt_d;
  logic [1:0]                    lane_q, lane_d;
  logic [LANES-1:0][LANE_W-1:0]  acc_q, acc_d;
  logic                          stop_q, stop_d;
  logic                          push_q, push_d;
  logic [WORD_W-1:0]             push_word_q, push_word_d;
  logic                          push_last_q, push_last_d;
  logic                          ovf_q, ovf_d;
  logic                          status_q, status_d;
  logic                          cfgerr_q, cfgerr_d;

  logic [LANES-1:0][LANE_W-1:0]  conv, acc_n;
  logic [1:0]                    idx;
  logic [2:0]                    npl, npl_in, lane_sum;
  logic [15:0]                   wnext;
  logic                          legal, stop_now, is_last;
  logic                          fifo_full, fifo_empty, fifo_pop;
  logic [WORD_W:0]               fifo_rd;

  // Per-channel widening: sign-extend, or left-align into the top 12 bits.
  for (genvar ch = 0; ch < LANES; ch++) begin : g_conv
    logic [SAMPLE_W-1:0] smp;
    assign smp      = adc_data[ch*SAMPLE_W +: SAMPLE_W];
    assign conv[ch] = signext_q ? {{(LANE_W-SAMPLE_W){smp[SAMPLE_W-1]}}, smp}
                                : {smp, {(LANE_W-SAMPLE_W){1'b0}}};
  end

  assign npl      = lanes_per_sample(mask_q);
  assign npl_in   = lanes_per_sample(cfg_enable);
  assign legal    = (npl_in == 3'd1) || (npl_in == 3'd2) || (npl_in == 3'd4);
  assign lane_sum = {1'b0, lane_q} + npl;
  assign wnext    = wcnt_q + 16'd1;
  assign stop_now = stop_q || cap_stop;
  assign is_last  = ((count_q != 16'd0) && (wnext == count_q)) || stop_now;
  assign fifo_pop = m_valid && m_ready;

  // Enabled channels fill consecutive lanes starting at the next free lane.
  // The lane position is always a multiple of npl, so no sample wraps a word.
  always_comb begin
    acc_n = acc_q;
    idx   = lane_q;
    for (int k = 0; k < LANES; k++) begin
      if (mask_q[k]) begin
        acc_n[idx] = conv[k];
        idx        = idx + 2'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    signext_d   = signext_q;
    count_d     = count_q;
    wcnt_d      = wcnt_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    stop_d      = stop_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    push_last_d = 1'b0;
    ovf_d       = ovf_q;
    status_d    = status_q;
    cfgerr_d    = cfgerr_q;

    // Registered word lands in the FIFO this cycle; dropped if no room.
    if (push_q && fifo_full && !fifo_pop) ovf_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (cap_start) begin
          if (legal) begin
            state_d   = RUN;
            mask_d    = cfg_enable;
            signext_d = cfg_signext;
            count_d   = cap_count;
            wcnt_d    = '0;
            lane_d    = '0;
            acc_d     = '0;
            stop_d    = 1'b0;
            ovf_d     = 1'b0;
            status_d  = 1'b0;
            cfgerr_d  = 1'b0;
          end else begin
            cfgerr_d = 1'b1;
          end
        end
      end
      RUN: begin
        stop_d = stop_now;
        if (adc_valid) begin
          if (!adc_status) status_d = 1'b1;
          if (lane_sum == 3'd4) begin
            push_d      = 1'b1;
            push_word_d = acc_n;
            push_last_d = is_last;
            wcnt_d      = wnext;
            lane_d      = '0;
            // Leave RUN on the completing cycle so later samples are ignored
            // even while the last word is still in the push register.
            if (is_last) state_d = DRAIN;
          end else begin
            acc_d  = acc_n;
            lane_d = lane_sum[1:0];
          end
        end
      end
      DRAIN: begin
        if (fifo_empty && !push_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      signext_q   <= 1'b0;
      count_q     <= '0;
      wcnt_q      <= '0;
      lane_q      <= '0;
      acc_q       <= '0;
      stop_q      <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      push_last_q <= 1'b0;
      ovf_q       <= 1'b0;
      status_q    <= 1'b0;
      cfgerr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      signext_q   <= signext_d;
      count_q     <= count_d;
      wcnt_q      <= wcnt_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      stop_q      <= stop_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      push_last_q <= push_last_d;
      ovf_q       <= ovf_d;
      status_q    <= status_d;
      cfgerr_q    <= cfgerr_d;
    end
  end

  ad_sfifo #(
    .WIDTH (WORD_W + 1),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_q),
    .wr_data ({push_last_q, push_word_q}),
    .rd_en   (m_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_rd[WORD_W-1:0];
  assign m_last     = fifo_rd[WORD_W];
  assign busy       = (state_q != IDLE);
  assign ovf        = ovf_q;
  assign status_err = status_q;
  assign cfg_err    = cfgerr_q;

endmodule

// File: tb/tb_ad9361_adc_pack.sv
// Scoreboard bench for ad9361_adc_pack: the driver feeds a sample-queue model
// that predicts packed words; a monitor pops predictions on each handshake.
module tb_ad9361_adc_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_valid = 1'b0, adc_status = 1'b1;
  logic [47:0] adc_data = '0;
  logic [3:0]  cfg_enable = '0;
  logic        cfg_signext = 1'b0;
  logic [15:0] cap_count = '0;
  logic        cap_start = 1'b0, cap_stop = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_valid, m_last, busy, ovf, status_err, cfg_err;
  logic [63:0] m_data;

  ad9361_adc_pack #(.FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .adc_valid(adc_valid), .adc_data(adc_data),
    .adc_status(adc_status), .cfg_enable(cfg_enable), .cfg_signext(cfg_signext),
    .cap_count(cap_count), .cap_start(cap_start), .cap_stop(cap_stop),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .ovf(ovf), .status_err(status_err), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;  // 0 hold low, 1 hold high, 2 random

  // Reference model state
  bit          mdl_idle = 1'b1, mdl_run = 1'b0, mdl_stop = 1'b0, mdl_se = 1'b0;
  logic [3:0]  mdl_mask = '0;
  int          mdl_cnt = 0, mdl_words = 0, drop_lo = 1, drop_hi = 0;
  bit          e_ovf = 1'b0, e_stat = 1'b0, e_cfg = 1'b0;
  logic [15:0] lanes[$];
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] conv16(input logic [11:0] s, input bit se);
    int v;
    if (se) begin
      v = s[11] ? int'(s) - 4096 : int'(s);
      return v[15:0];
    end
    v = int'(s) * 16;
    return v[15:0];
  endfunction

  task automatic model_step(input bit v, input logic [47:0] d, input bit st,
                            input bit stop, input bit start);
    if (start && mdl_idle) begin
      int pc;
      pc = $countones(cfg_enable);
      if (pc == 1 || pc == 2 || pc == 4) begin
        mdl_idle = 0; mdl_run = 1; mdl_stop = 0; mdl_mask = cfg_enable;
        mdl_se = cfg_signext; mdl_cnt = int'(cap_count); mdl_words = 0;
        lanes.delete(); e_ovf = 0; e_stat = 0; e_cfg = 0;
      end else begin
        e_cfg = 1;
      end
    end else if (mdl_run) begin
      if (stop) mdl_stop = 1;
      if (v) begin
        if (!st) e_stat = 1;
        for (int k = 0; k < 4; k++)
          if (mdl_mask[k]) lanes.push_back(conv16(d[k*12 +: 12], mdl_se));
        if (lanes.size() == 4) begin
          bit last;
          mdl_words++;
          last = (mdl_cnt != 0 && mdl_words == mdl_cnt) || mdl_stop;
          if (mdl_words >= drop_lo && mdl_words <= drop_hi) e_ovf = 1;
          else exp_q.push_back({last, lanes[3], lanes[2], lanes[1], lanes[0]});
          if (last) mdl_run = 0;
          lanes.delete();
        end
      end
    end
  endtask

  task automatic drive(input bit v, input logic [47:0] d, input bit st,
                       input bit stop, input bit start);
    adc_valid = v; adc_data = d; adc_status = st; cap_stop = stop; cap_start = start;
    model_step(v, d, st, stop, start);
    @(posedge clk); #1;
    adc_valid = 0; cap_stop = 0; cap_start = 0; adc_status = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, '0, 1, 0, 0);
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic wait_q(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin idle(1); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending %0d expected 0", name, exp_q.size());
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin idle(1); n++; end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_idle: busy %0b pending %0d expected 0 0", name, busy, exp_q.size());
    end
    mdl_idle = 1;
  endtask

  // Monitor: compare each accepted word against the next prediction.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %h expected none", {m_last, m_data});
      end else begin
        mon_e = exp_q.pop_front();
        check("word", {m_last, m_data}, mon_e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = ($urandom_range(3) != 0);
    endcase
  end

  localparam logic [3:0] LEGAL [11] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5,
                                        4'h6, 4'h9, 4'hA, 4'hC, 4'hF};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_flags", {m_last, busy, ovf, status_err, cfg_err}, 0);
    rst = 0;
    idle(2);

    // Four channels, sign-extend, two words
    rdy_mode = 1;
    cfg_enable = 4'hF; cfg_signext = 1; cap_count = 16'd2;
    drive(0, '0, 1, 0, 1);
    check("t1_busy_rise", busy, 1);
    drive(1, {12'hFFF, 12'h001, 12'h7FF, 12'h800}, 1, 0, 0);
    drive(1, {4{12'h123}}, 1, 0, 0);
    wait_idle("t1");
    check("t1_busy_fall", busy, 0);

    // Single channel, left-aligned, latency check
    rdy_mode = 0;
    cfg_enable = 4'h1; cfg_signext = 0; cap_count = 16'd1;
    drive(0, '0, 1, 0, 1);
    drive(1, 48'h001, 1, 0, 0);
    drive(1, 48'h002, 1, 0, 0);
    drive(1, 48'h003, 1, 0, 0);
    drive(1, 48'h004, 1, 0, 0);
    check("t2_valid_lat1", m_valid, 0);
    idle(1);
    check("t2_valid_lat2", m_valid, 1);
    check("t2_word", {m_last, m_data}, {1'b1, 64'h0040_0030_0020_0010});
    rdy_mode = 1;
    wait_idle("t2");

    // Two channels, continuous, stop mid-word
    rdy_mode = 2;
    cfg_enable = 4'h3; cfg_signext = 1'($urandom); cap_count = 16'd0;
    drive(0, '0, 1, 0, 1);
    repeat (3) drive(1, rnd48(), 1, 0, 0);
    drive(0, '0, 1, 1, 0);
    drive(1, rnd48(), 1, 0, 0);
    repeat (5) drive(1, rnd48(), 1, 0, 0);
    wait_idle("t3");

    // Overflow: 20 words into a 16-deep FIFO with the consumer stalled
    rdy_mode = 0;
    drop_lo = 17; drop_hi = 20;
    cfg_enable = 4'hF; cfg_signext = 1; cap_count = 16'd0;
    drive(0, '0, 1, 0, 1);
    repeat (20) drive(1, rnd48(), 1, 0, 0);
    idle(2);
    check("t4_ovf", ovf, e_ovf);
    check("t4_held", m_valid, 1);
    rdy_mode = 1;
    wait_q("t4");
    drive(1, rnd48(), 1, 1, 0);
    wait_idle("t4");
    check("t4_ovf_sticky", ovf, 1);
    drop_lo = 1; drop_hi = 0;

    // Illegal mask, then legal start with a status error
    cfg_enable = 4'h7;
    drive(0, '0, 1, 0, 1);
    check("t5_cfg_err", cfg_err, 1);
    check("t5_busy", busy, 0);
    idle(3);
    check("t5_no_out", {m_valid, busy}, 0);
    cfg_enable = 4'h5; cfg_signext = 1'($urandom); cap_count = 16'd3;
    drive(0, '0, 1, 0, 1);
    check("t5_cfg_clear", cfg_err, 0);
    check("t5_ovf_clear", ovf, 0);
    for (int i = 0; i < 6; i++) drive(1, rnd48(), (i != 1), 0, 0);
    check("t6_status_err", status_err, e_stat);
    wait_idle("t6");
    check("t6_status_sticky", status_err, 1);

    // Reset mid-capture
    rdy_mode = 0;
    cfg_enable = 4'hF; cap_count = 16'd0;
    drive(0, '0, 1, 0, 1);
    drive(1, rnd48(), 0, 0, 0);
    drive(1, rnd48(), 1, 0, 0);
    idle(2);
    rst = 1;
    @(posedge clk); #1;
    check("t7_rst_valid", m_valid, 0);
    check("t7_rst_flags", {busy, ovf, status_err, cfg_err}, 0);
    rst = 0;
    exp_q.delete(); lanes.delete();
    mdl_run = 0; mdl_idle = 1; e_ovf = 0; e_stat = 0; e_cfg = 0;
    idle(3);
    check("t7_after_rst", {m_valid, busy}, 0);

    // Randomized captures
    for (int c = 0; c < 25; c++) begin
      bit cont;
      int tw, n;
      rdy_mode = 2;
      repeat ($urandom_range(3)) drive(1'($urandom), rnd48(), 1'($urandom), 0, 0);
      check("rnd_idle_flags", {ovf, status_err, cfg_err}, {e_ovf, e_stat, e_cfg});
      cfg_enable = LEGAL[$urandom_range(10)];
      cfg_signext = 1'($urandom);
      cont = ($urandom_range(3) == 0);
      cap_count = cont ? 16'd0 : 16'($urandom_range(12, 1));
      tw = $urandom_range(10, 1);
      drive(0, '0, 1, 0, 1);
      n = 0;
      while (mdl_run && n < 400) begin
        bit v, st, sp, ss;
        v  = ($urandom_range(2) != 0);
        st = ($urandom_range(15) != 0);
        sp = (cont ? (mdl_words >= tw) : ($urandom_range(30) == 0)) && ($urandom_range(1) == 1);
        ss = ($urandom_range(20) == 0);
        if (ss) cfg_enable = 4'($urandom);
        drive(v, rnd48(), st, sp, ss);
        n++;
      end
      checks++;
      if (mdl_run) begin
        errors++;
        $display("FAIL rnd_capture_end: still running after %0d cycles", n);
      end
      wait_idle("rnd");
      check("rnd_flags", {ovf, status_err, cfg_err}, {e_ovf, e_stat, e_cfg});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
